// File: rtl/bmc_pkg.sv
// Shared constants and state encoding for the Lighthouse V2 BMC front end.
// pulse_identifier's >>4 timestamp scaling assumes TICKS_PER_BIT stays 16.
package bmc_pkg;

  localparam int NBITS         = 17;
  localparam int TS_WIDTH      = 24;
  localparam int TICKS_PER_BIT = 16;
  localparam int HALF_BIT      = TICKS_PER_BIT / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } bmc_state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous sensor pin, plus a toggle detector
// on the synchronised level.
module edge_sync (
  input  logic clk_96MHz,
  input  logic async_in,
  output logic sync_out,
  output logic edge_out
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // No reset: a stable pin then never produces a spurious edge when reset lifts.
  always_ff @(posedge clk_96MHz) begin
    meta_q <= async_in;
    sync_q <= meta_q;
    prev_q <= sync_q;
  end

  assign sync_out = sync_q;
  assign edge_out = sync_q ^ prev_q;

endmodule

// File: rtl/bmc_decoder.sv
// Per-sensor BMC decoder: captures the first NBITS bits of a sweep and the
// sys_ts of the edge opening bit 0, then holds them until reset.
//
// state  | meaning
// IDLE   | waiting for the first D edge with the envelope active
// DECODE | classifying D edge intervals into half/full bits
// DONE   | word captured, outputs frozen until reset
module bmc_decoder
  import bmc_pkg::*;
#(
  parameter int SHORT_MIN = 5,
  parameter int SHORT_MAX = 11,
  parameter int LONG_MAX  = 22
) (
  input  logic                clk_96MHz,
  input  logic                reset,
  input  logic                sensor_e,
  input  logic                sensor_d,
  input  logic [TS_WIDTH-1:0] sys_ts,
  output logic [NBITS-1:0]    decoded_data,
  output logic [TS_WIDTH-1:0] ts_data,
  output logic                data_availible
);

  localparam logic [5:0] SHORT_MIN_V = 6'(SHORT_MIN);
  localparam logic [5:0] SHORT_MAX_V = 6'(SHORT_MAX);
  localparam logic [5:0] LONG_MAX_V  = 6'(LONG_MAX);
  localparam logic [4:0] LAST_BIT    = 5'(NBITS - 1);

  logic e_sync, e_edge, d_sync, d_edge, e_rise;

  edge_sync u_sync_e (
    .clk_96MHz (clk_96MHz),
    .async_in  (sensor_e),
    .sync_out  (e_sync),
    .edge_out  (e_edge)
  );

  edge_sync u_sync_d (
    .clk_96MHz (clk_96MHz),
    .async_in  (sensor_d),
    .sync_out  (d_sync),
    .edge_out  (d_edge)
  );

  bmc_state_e          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [4:0]          bits_q, bits_d;
  logic                half_q, half_d;
  logic [NBITS-1:0]    shreg_q, shreg_d;
  logic [TS_WIDTH-1:0] ts_begin_q, ts_begin_d;
  logic [NBITS-1:0]    dec_d;
  logic [TS_WIDTH-1:0] tsd_d;
  logic                dav_d;
  logic [5:0]          interval;
  logic                short_win, long_win, too_long;

  // The envelope can only rise while decoding, since IDLE requires it low.
  assign e_rise = e_edge & e_sync;

  // Ticks since the previous accepted edge, counting the current cycle.
  assign interval  = {1'b0, cnt_q} + 6'd1;
  assign short_win = (interval >= SHORT_MIN_V) && (interval <= SHORT_MAX_V);
  assign long_win  = (interval > SHORT_MAX_V) && (interval <= LONG_MAX_V);
  assign too_long  = (interval > LONG_MAX_V);

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bits_q         <= '0;
      half_q         <= 1'b0;
      shreg_q        <= '0;
      ts_begin_q     <= '0;
      decoded_data   <= '0;
      ts_data        <= '0;
      data_availible <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bits_q         <= bits_d;
      half_q         <= half_d;
      shreg_q        <= shreg_d;
      ts_begin_q     <= ts_begin_d;
      decoded_data   <= dec_d;
      ts_data        <= tsd_d;
      data_availible <= dav_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    bits_d     = bits_q;
    half_d     = half_q;
    shreg_d    = shreg_q;
    ts_begin_d = ts_begin_q;
    dec_d      = decoded_data;
    tsd_d      = ts_data;
    dav_d      = data_availible;

    case (state_q)
      IDLE: begin
        if (d_edge && !e_sync) begin
          state_d    = DECODE;
          cnt_d      = '0;
          bits_d     = '0;
          half_d     = 1'b0;
          ts_begin_d = sys_ts;
        end
      end

      DECODE: begin
        if (e_rise) begin
          state_d = IDLE;
        end else if (d_edge) begin
          cnt_d = '0;
          if (short_win && !half_q) begin
            half_d = 1'b1;
          end else if (short_win || (long_win && !half_q)) begin
            shreg_d = {shreg_q[NBITS-2:0], short_win};
            bits_d  = bits_q + 5'd1;
            half_d  = 1'b0;
            if (bits_q == LAST_BIT) begin
              state_d = DONE;
              dec_d   = shreg_d;
              tsd_d   = ts_begin_q;
              dav_d   = 1'b1;
            end
          end else begin
            // Glitch, long after a lone half-bit, or overlong gap: this edge opens a new bit 0.
            ts_begin_d = sys_ts;
            bits_d     = '0;
            half_d     = 1'b0;
          end
        end else if (too_long) begin
          state_d = IDLE;
        end
      end

      DONE: begin
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bmc_decoder.sv
// Directed bench for bmc_decoder: BMC bursts built from tick-accurate D toggles,
// expected words and timestamps written out by hand.
module tb_bmc_decoder;
  import bmc_pkg::*;

  logic                clk_96MHz = 1'b0;
  logic                reset;
  logic                sensor_e;
  logic                sensor_d;
  logic [TS_WIDTH-1:0] sys_ts;
  logic [NBITS-1:0]    decoded_data;
  logic [TS_WIDTH-1:0] ts_data;
  logic                data_availible;

  int n_pass  = 0;
  int n_total = 0;

  bmc_decoder dut (
    .clk_96MHz      (clk_96MHz),
    .reset          (reset),
    .sensor_e       (sensor_e),
    .sensor_d       (sensor_d),
    .sys_ts         (sys_ts),
    .decoded_data   (decoded_data),
    .ts_data        (ts_data),
    .data_availible (data_availible)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  task automatic tick();
    @(posedge clk_96MHz);
    #1;
    sys_ts = sys_ts + 24'd1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic toggle_d();
    sensor_d = ~sensor_d;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // The decoder latches sys_ts two increments after the toggle is driven.
  task automatic send_word(input logic [16:0] w, input int nbits, input bit jit,
                           input bit start, output logic [23:0] ts0);
    int h;
    ts0 = sys_ts + 24'd2;
    if (start) toggle_d();
    for (int k = 0; k < nbits; k++) begin
      if (w[16-k]) begin
        h = jit ? ((k % 2) ? 9 : 7) : HALF_BIT;
        wait_ticks(h);
        toggle_d();
        wait_ticks(TICKS_PER_BIT - h);
        toggle_d();
      end else begin
        h = jit ? ((k % 2) ? 17 : 15) : TICKS_PER_BIT;
        wait_ticks(h);
        toggle_d();
      end
    end
  endtask

  logic [23:0] ts0;
  logic [23:0] ts_pe;

  initial begin
    reset    = 1'b1;
    sensor_e = 1'b1;
    sensor_d = 1'b0;
    sys_ts   = '0;
    wait_ticks(6);
    check("reset_dav", {63'd0, data_availible}, 64'd0);
    check("reset_data", {47'd0, decoded_data}, 64'd0);
    check("reset_ts", {40'd0, ts_data}, 64'd0);
    reset = 1'b0;

    // Clean nominal burst
    sensor_e = 1'b0;
    wait_ticks(4);
    sys_ts = 24'h0000FE;
    send_word(17'h1A5C3, 17, 1'b0, 1'b1, ts0);
    wait_ticks(5);
    check("clean_dav", {63'd0, data_availible}, 64'd1);
    check("clean_data", {47'd0, decoded_data}, 64'h1A5C3);
    check("clean_ts", {40'd0, ts_data}, 64'h000100);

    // Jittered burst across a sys_ts wrap
    pulse_reset();
    check("rst1_dav", {63'd0, data_availible}, 64'd0);
    wait_ticks(3);
    sys_ts = 24'hFFFFFE;
    send_word(17'h1A5C3, 17, 1'b1, 1'b1, ts0);
    wait_ticks(5);
    check("jit_dav", {63'd0, data_availible}, 64'd1);
    check("jit_data", {47'd0, decoded_data}, 64'h1A5C3);
    check("jit_ts", {40'd0, ts_data}, 64'h000000);

    // Envelope lost after 10 bits, D toggles while dark, then a fresh burst
    pulse_reset();
    wait_ticks(3);
    send_word(17'h1A5C3, 10, 1'b0, 1'b1, ts0);
    wait_ticks(4);
    sensor_e = 1'b1;
    wait_ticks(8);
    for (int i = 0; i < 3; i++) begin
      toggle_d();
      wait_ticks(8);
    end
    wait_ticks(30);
    check("abort_dav", {63'd0, data_availible}, 64'd0);
    check("abort_data", {47'd0, decoded_data}, 64'd0);
    sensor_e = 1'b0;
    wait_ticks(4);
    sys_ts = 24'h123450;
    send_word(17'h00001, 17, 1'b0, 1'b1, ts0);
    wait_ticks(5);
    check("after_abort_dav", {63'd0, data_availible}, 64'd1);
    check("after_abort_data", {47'd0, decoded_data}, 64'h00001);
    check("after_abort_ts", {40'd0, ts_data}, 64'h123452);

    // Phase error: 4 ones, a short then a long; the long-ending edge opens bit 0
    pulse_reset();
    wait_ticks(3);
    send_word(17'h1FFFF, 4, 1'b0, 1'b1, ts0);
    wait_ticks(HALF_BIT);
    toggle_d();
    wait_ticks(TICKS_PER_BIT);
    sys_ts = 24'h00ABC0;
    toggle_d();
    send_word(17'h1FFFF, 17, 1'b0, 1'b0, ts_pe);
    wait_ticks(5);
    check("phase_dav", {63'd0, data_availible}, 64'd1);
    check("phase_data", {47'd0, decoded_data}, 64'h1FFFF);
    check("phase_ts", {40'd0, ts_data}, 64'h00ABC2);

    // Burst while in DONE must not disturb the held word
    send_word(17'h0AAAA, 17, 1'b0, 1'b1, ts0);
    wait_ticks(5);
    check("done_hold_dav", {63'd0, data_availible}, 64'd1);
    check("done_hold_data", {47'd0, decoded_data}, 64'h1FFFF);
    check("done_hold_ts", {40'd0, ts_data}, 64'h00ABC2);
    pulse_reset();
    check("done_rst_dav", {63'd0, data_availible}, 64'd0);
    check("done_rst_data", {47'd0, decoded_data}, 64'd0);
    check("done_rst_ts", {40'd0, ts_data}, 64'd0);
    wait_ticks(3);
    sys_ts = 24'h000400;
    send_word(17'h0F0F0, 17, 1'b0, 1'b1, ts0);
    wait_ticks(5);
    check("next_dav", {63'd0, data_availible}, 64'd1);
    check("next_data", {47'd0, decoded_data}, 64'h0F0F0);
    check("next_ts", {40'd0, ts_data}, 64'h000402);

    // Reset sampled on the same cycle the 17th bit completes
    pulse_reset();
    wait_ticks(3);
    send_word(17'h15555, 17, 1'b0, 1'b1, ts0);
    wait_ticks(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("race_dav", {63'd0, data_availible}, 64'd0);
    check("race_data", {47'd0, decoded_data}, 64'd0);
    check("race_ts", {40'd0, ts_data}, 64'd0);
    wait_ticks(30);
    check("race_dav_late", {63'd0, data_availible}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
